// File: rtl/digit_seq_pkg.sv
// Shared types and helpers for the sequential digit comparator.
//
// Contents:
//   state_t   - entry FSM states (IDLE, COLLECT, DONE)
//   decide_t  - running comparison decision (UNDECIDED, DEC_GT, DEC_LT)
//   digit_at  - pick one digit out of a packed code. Digit 0 is the most
//               significant digit and sits in the top DIGIT_W bits.
package digit_seq_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  typedef enum logic [1:0] {UNDECIDED, DEC_GT, DEC_LT} decide_t;

  // Widest code and digit the helper can handle. Callers zero-extend their
  // code to MAX_CODE_W bits and compare the returned digit at MAX_DIGIT_W bits.
  localparam int MAX_CODE_W  = 256;
  localparam int MAX_DIGIT_W = 32;

  function automatic logic [MAX_DIGIT_W-1:0] digit_at(
    input logic [MAX_CODE_W-1:0] code,
    input logic [31:0]           idx,
    input logic [31:0]           digit_w,
    input logic [31:0]           num_digits
  );
    logic [MAX_DIGIT_W-1:0] mask;
    mask = (digit_w >= 32'd32) ? '1 : ((32'd1 << digit_w) - 32'd1);
    return MAX_DIGIT_W'(code >> ((num_digits - 32'd1 - idx) * digit_w)) & mask;
  endfunction

endpackage

// File: rtl/digit_seq_comparator_lockout_timer.sv
// Lockout timer for the digit comparator: counts consecutive failed
// entries and, once MAX_FAILS is reached, holds 'locked' high for
// LOCK_CYCLES clock cycles.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   result_valid - high for the single cycle in which a comparison completes
//   result_eq    - comparison outcome, valid while result_valid is high
//   locked       - lockout active
module digit_seq_comparator_lockout_timer #(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic result_valid,
  input  logic result_eq,
  output logic locked
);

  localparam int FAIL_W  = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1);
  localparam int TIMER_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCK_CYCLES);

  logic [FAIL_W-1:0]  fail_q,   fail_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic               locked_q, locked_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_q   <= '0;
      timer_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      locked_q <= locked_d;
    end
  end

  // The timer holds the number of locked cycles still to go, counting the
  // current one, so the lock lasts exactly LOCK_CYCLES cycles. No result can
  // complete while locked, because new entries are refused.
  always_comb begin
    fail_d   = fail_q;
    timer_d  = timer_q;
    locked_d = locked_q;
    if (locked_q) begin
      if (timer_q <= TIMER_W'(1)) begin
        locked_d = 1'b0;
        timer_d  = '0;
        fail_d   = '0;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end else if (result_valid) begin
      if (result_eq) begin
        fail_d = '0;
      end else if ((fail_q + FAIL_W'(1)) >= FAIL_LIMIT) begin
        fail_d   = FAIL_LIMIT;
        locked_d = 1'b1;
        timer_d  = LOCK_LOAD;
      end else begin
        fail_d = fail_q + FAIL_W'(1);
      end
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/digit_seq_comparator.sv
// Sequential digit-code comparator. It takes NUM_DIGITS digits of DIGIT_W
// bits, one per digit_valid strobe with the most significant digit first,
// and compares them against a stored reference code. The result is reported
// as equal / greater / less the cycle after the last digit.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   code_load    - capture code_in as the reference. This aborts an entry
//                  in progress.
//   code_in      - reference code, digit 0 (MS) in the top DIGIT_W bits
//   digit_valid  - one-cycle strobe qualifying digit_in
//   digit_in     - entered digit
//   clear        - abort the entry and clear the result flags
//   busy         - entry in progress
//   done         - one-cycle pulse when the comparison completes
//   eq / gt / lt - result flags. They are held until the next entry starts.
//   count        - digits accepted so far in the current entry
//   locked       - lockout active (always 0 unless the lockout is built in)
//
// Build option: define DIGIT_SEQ_LOCKOUT_EN to add the failed-attempt
// lockout (MAX_FAILS consecutive mismatches lock out entry for LOCK_CYCLES).
module digit_seq_comparator
  import digit_seq_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 2,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 50
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              code_load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     code_in,
  input  logic                              digit_valid,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              clear,
  output logic                              busy,
  output logic                              done,
  output logic                              eq,
  output logic                              gt,
  output logic                              lt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              locked
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS);

  state_t                 state_q, state_d;
  decide_t                dec_q,   dec_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CODE_W-1:0]      ref_q,   ref_d;
  logic                   eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic                   locked_int;
  logic                   take_digit;
  logic                   abort_entry;
  logic [CNT_W-1:0]       digit_idx;
  logic [CNT_W-1:0]       count_next;
  logic [MAX_DIGIT_W-1:0] ref_digit;
  logic [MAX_DIGIT_W-1:0] entered_digit;
  decide_t                digit_dec;
  decide_t                step_dec;

`ifdef DIGIT_SEQ_LOCKOUT_EN
  digit_seq_comparator_lockout_timer #(
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clk          (clk),
    .reset        (reset),
    .result_valid (state_q == DONE),
    .result_eq    (eq_q),
    .locked       (locked_int)
  );
`else
  assign locked_int = 1'b0;
  logic unused_lock_params;
  assign unused_lock_params = ^{MAX_FAILS, LOCK_CYCLES};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dec_q   <= UNDECIDED;
      count_q <= '0;
      ref_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      count_q <= count_d;
      ref_q   <= ref_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // A load always wins over a digit in the same cycle, so the digit is never
  // compared against a reference that is being replaced.
  assign take_digit  = digit_valid && !code_load && !locked_int;
  assign abort_entry = clear || (code_load && (state_q == COLLECT));

  // The first digit of an entry is always digit 0, whatever count shows.
  assign digit_idx     = (state_q == IDLE) ? '0 : count_q;
  assign count_next    = digit_idx + CNT_W'(1);
  assign ref_digit     = digit_at({{(MAX_CODE_W-CODE_W){1'b0}}, ref_q},
                                  32'(digit_idx), 32'(DIGIT_W), 32'(NUM_DIGITS));
  assign entered_digit = MAX_DIGIT_W'(digit_in);

  always_comb begin
    digit_dec = UNDECIDED;
    if (entered_digit > ref_digit) begin
      digit_dec = DEC_GT;
    end else if (entered_digit < ref_digit) begin
      digit_dec = DEC_LT;
    end
  end

  // Once a digit differs, that decision sticks for the rest of the entry.
  assign step_dec = ((state_q == IDLE) || (dec_q == UNDECIDED)) ? digit_dec : dec_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    count_d = count_q;
    ref_d   = ref_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;

    if (code_load) begin
      ref_d = code_in;
    end

    if (abort_entry) begin
      state_d = IDLE;
      dec_d   = UNDECIDED;
      count_d = '0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (take_digit) begin
            dec_d   = step_dec;
            count_d = count_next;
            if (state_q == IDLE) begin
              eq_d = 1'b0;
              gt_d = 1'b0;
              lt_d = 1'b0;
            end
            if (count_next == LAST_CNT) begin
              state_d = DONE;
              eq_d    = (step_dec == UNDECIDED);
              gt_d    = (step_dec == DEC_GT);
              lt_d    = (step_dec == DEC_LT);
            end else begin
              state_d = COLLECT;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          dec_d   = UNDECIDED;
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
          dec_d   = UNDECIDED;
          count_d = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy   = (state_q == COLLECT);
    done   = (state_q == DONE);
    eq     = eq_q;
    gt     = gt_q;
    lt     = lt_q;
    count  = count_q;
    locked = locked_int;
  end

endmodule

// File: tb/tb_digit_seq_comparator.sv
// Testbench for digit_seq_comparator. Two instances are used: a 2-digit one
// and a 4-digit one. Expected results come from comparing the entered digits
// and the reference code as plain unsigned numbers.
module tb_digit_seq_comparator;

  localparam int MAXF  = 3;
  localparam int LOCKC = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        code_load_a = 1'b0, digit_valid_a = 1'b0, clear_a = 1'b0;
  logic [7:0]  code_in_a = '0;
  logic [3:0]  digit_in_a = '0;
  logic        busy_a, done_a, eq_a, gt_a, lt_a, locked_a;
  logic [1:0]  count_a;

  logic        code_load_b = 1'b0, digit_valid_b = 1'b0, clear_b = 1'b0;
  logic [15:0] code_in_b = '0;
  logic [3:0]  digit_in_b = '0;
  logic        busy_b, done_b, eq_b, gt_b, lt_b, locked_b;
  logic [2:0]  count_b;

  digit_seq_comparator #(.DIGIT_W(4), .NUM_DIGITS(2), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC)) dut_a (
    .clk(clk), .reset(reset), .code_load(code_load_a), .code_in(code_in_a),
    .digit_valid(digit_valid_a), .digit_in(digit_in_a), .clear(clear_a),
    .busy(busy_a), .done(done_a), .eq(eq_a), .gt(gt_a), .lt(lt_a),
    .count(count_a), .locked(locked_a)
  );

  digit_seq_comparator #(.DIGIT_W(4), .NUM_DIGITS(4), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC)) dut_b (
    .clk(clk), .reset(reset), .code_load(code_load_b), .code_in(code_in_b),
    .digit_valid(digit_valid_b), .digit_in(digit_in_b), .clear(clear_b),
    .busy(busy_b), .done(done_b), .eq(eq_b), .gt(gt_b), .lt(lt_b),
    .count(count_b), .locked(locked_b)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  exp_flags [2];
  int          fails [2];
  int          ndig [2] = '{2, 4};
  logic [15:0] cur_code;
  logic [15:0] val;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Packed view: busy, done, eq, gt, lt, locked, count[2:0]
  function automatic logic [8:0] obs(input int sel);
    if (sel == 0) return {busy_a, done_a, eq_a, gt_a, lt_a, locked_a, 1'b0, count_a};
    return {busy_b, done_b, eq_b, gt_b, lt_b, locked_b, count_b};
  endfunction

  function automatic logic [8:0] expv(input logic b, input logic d, input logic [2:0] f,
                                      input logic lk, input int cnt);
    return {b, d, f, lk, 3'(cnt)};
  endfunction

  // Lexicographic digit order is numeric order of the packed values.
  function automatic logic [2:0] model(input logic [15:0] entered, input logic [15:0] code);
    if (entered == code) return 3'b100;
    if (entered > code)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic applyStimulus(input int sel, input logic ld, input logic [15:0] code,
                               input logic dv, input logic [3:0] d, input logic clr);
    @(negedge clk);
    code_load_a = 1'b0; digit_valid_a = 1'b0; clear_a = 1'b0;
    code_load_b = 1'b0; digit_valid_b = 1'b0; clear_b = 1'b0;
    if (sel == 0) begin
      code_load_a = ld; code_in_a = code[7:0]; digit_valid_a = dv; digit_in_a = d; clear_a = clr;
    end else begin
      code_load_b = ld; code_in_b = code; digit_valid_b = dv; digit_in_b = d; clear_b = clr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    code_load_a = 1'b0; digit_valid_a = 1'b0; clear_a = 1'b0;
    code_load_b = 1'b0; digit_valid_b = 1'b0; clear_b = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_a", obs(0), expv(0, 0, 3'b000, 0, 0));
    checkOutput("reset_b", obs(1), expv(0, 0, 3'b000, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    exp_flags[0] = 3'b000; exp_flags[1] = 3'b000;
    fails[0] = 0; fails[1] = 0;
  endtask

  // Drives digits every cycle while locked; none may be accepted, and clear
  // must not shorten the lock.
  task automatic waitLockout(input int sel);
    logic [8:0] o;
    logic       clr;
    int         held = 1;
    for (int k = 0; k < 4 * LOCKC + 10; k++) begin
      clr = ((k % 7) == 3);
      applyStimulus(sel, 1'b0, 16'h0, 1'b1, 4'($urandom), clr);
      if (clr) exp_flags[sel] = 3'b000;
      o = obs(sel);
      checkOutput("lock_ignore", {o[8:4], o[2:0]}, {2'b00, exp_flags[sel], 3'b000});
      if (o[3]) held++;
      else break;
    end
    checkOutput("lock_len", held, LOCKC);
  endtask

  task automatic enterCode(input int sel, input logic [15:0] value, input logic [15:0] code,
                           input bit gaps, input bit dv_in_done);
    logic [2:0] f;
    logic [3:0] d;
    int         n;
    n = ndig[sel];
    f = model(value, code);
    for (int i = 0; i < n; i++) begin
      d = 4'(value >> (4 * (n - 1 - i)));
      applyStimulus(sel, 1'b0, 16'h0, 1'b1, d, 1'b0);
      if (i < n - 1) begin
        exp_flags[sel] = 3'b000;
        checkOutput("collect", obs(sel), expv(1, 0, 3'b000, 0, i + 1));
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            applyStimulus(sel, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
            checkOutput("gap", obs(sel), expv(1, 0, 3'b000, 0, i + 1));
          end
        end
      end
    end
    exp_flags[sel] = f;
    checkOutput("done", obs(sel), expv(0, 1, f, 0, n));
    fails[sel] = (f == 3'b100) ? 0 : fails[sel] + 1;
    applyStimulus(sel, 1'b0, 16'h0, dv_in_done, 4'($urandom), 1'b0);
`ifdef DIGIT_SEQ_LOCKOUT_EN
    if (fails[sel] >= MAXF) begin
      checkOutput("lock_on", obs(sel), expv(0, 0, f, 1, 0));
      waitLockout(sel);
      fails[sel] = 0;
    end else begin
      checkOutput("post_done", obs(sel), expv(0, 0, f, 0, 0));
    end
`else
    checkOutput("post_done", obs(sel), expv(0, 0, f, 0, 0));
`endif
  endtask

  task automatic loadCode(input int sel, input logic [15:0] code);
    applyStimulus(sel, 1'b1, code, 1'b0, 4'h0, 1'b0);
    checkOutput("load_idle", obs(sel), expv(0, 0, exp_flags[sel], 0, 0));
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting digit_seq_comparator bench");
    doReset();

    // Reference is 0 after reset
    enterCode(0, 16'h00, 16'h00, 0, 0);

    loadCode(0, 16'h37);
    enterCode(0, 16'h37, 16'h37, 0, 0);
    enterCode(0, 16'h40, 16'h37, 0, 0);
    enterCode(0, 16'h36, 16'h37, 0, 0);

    for (int v = 0; v < 256; v++) begin
      enterCode(0, 16'(v), 16'h37, 0, 0);
    end

    // clear wins over a digit in the same cycle
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 4'h3, 1'b0);
    exp_flags[0] = 3'b000;
    checkOutput("clr_first", obs(0), expv(1, 0, 3'b000, 0, 1));
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 4'h7, 1'b1);
    checkOutput("clr_abort", obs(0), expv(0, 0, 3'b000, 0, 0));
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("clr_nodone", obs(0), expv(0, 0, 3'b000, 0, 0));
    enterCode(0, 16'h37, 16'h37, 0, 0);

    // code_load mid-entry aborts it
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 4'h3, 1'b0);
    exp_flags[0] = 3'b000;
    checkOutput("ld_first", obs(0), expv(1, 0, 3'b000, 0, 1));
    applyStimulus(0, 1'b1, 16'h12, 1'b0, 4'h0, 1'b0);
    checkOutput("ld_abort", obs(0), expv(0, 0, 3'b000, 0, 0));
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("ld_nodone", obs(0), expv(0, 0, 3'b000, 0, 0));
    enterCode(0, 16'h12, 16'h12, 0, 0);

    // load and digit together in IDLE: digit dropped, flags kept
    applyStimulus(0, 1'b1, 16'h5A, 1'b1, 4'h5, 1'b0);
    checkOutput("ld_dv_idle", obs(0), expv(0, 0, exp_flags[0], 0, 0));
    enterCode(0, 16'h5A, 16'h5A, 0, 0);

    cur_code = 16'h5A;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_code = 16'($urandom_range(0, 255));
        loadCode(0, cur_code);
      end
      val = ($urandom_range(0, 2) == 0) ? cur_code : 16'($urandom_range(0, 255));
      enterCode(0, val, cur_code, 1, 0);
    end

    // Four-digit instance
    loadCode(1, 16'hBEEF);
    enterCode(1, 16'hBEEF, 16'hBEEF, 0, 0);
    enterCode(1, 16'hBEEE, 16'hBEEF, 0, 1);
    enterCode(1, 16'hBEEF, 16'hBEEF, 0, 1);
    enterCode(1, 16'hBFEE, 16'hBEEF, 1, 0);
    cur_code = 16'hBEEF;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_code = 16'($urandom);
        loadCode(1, cur_code);
      end
      val = ($urandom_range(0, 2) == 0) ? cur_code : 16'($urandom);
      enterCode(1, val, cur_code, 1, $urandom_range(0, 1) == 1);
    end

    // Three consecutive mismatches, then a correct entry
    doReset();
    loadCode(0, 16'h37);
    enterCode(0, 16'h38, 16'h37, 0, 0);
    enterCode(0, 16'h00, 16'h37, 0, 0);
    enterCode(0, 16'hFF, 16'h37, 0, 0);
    enterCode(0, 16'h37, 16'h37, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
